// File: rtl/rx_frame_controller.sv
// rx_frame_controller
//   Receive-path sequencer for the serial transceiver. It takes the
//   per-bit strobe (sample_sig) and line level (din) from the upstream
//   sampler and assembles DATA_BITS-wide words, LSB first. Completed words
//   go into a FIFO_DEPTH-entry first-word-fall-through FIFO, which the
//   consumer drains over a valid/ready handshake. Overrun and framing or
//   timeout errors are reported through sticky flags.
//
//   Optional feature macro: RX_STOP_CHECK_EN
//     defined   - after the data bits, one more strobe carries the stop bit.
//                 A stop level of 1 pushes the word. A stop level of 0
//                 drops the word and sets frame_err.
//     undefined - no stop bit is consumed; SHIFT goes straight to PUSH.
module rx_frame_controller #(
  parameter int DATA_BITS  = 8,   // 1..8
  parameter int FIFO_DEPTH = 4,   // power of 2, 2..16
  parameter int TIMEOUT    = 40   // max cycles between strobes inside a frame
) (
  input  logic       sample_clk,
  input  logic       rst_n,
  input  logic       sample_sig,
  input  logic       din,
  input  logic       clr_flags,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [4:0] level,
  output logic       busy,
  output logic       overrun,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef RX_STOP_CHECK_EN
    S_STOP  = 2'd3,
`endif
    S_PUSH  = 2'd2
  } state_t;

  // State entered once the last data bit has been captured.
`ifdef RX_STOP_CHECK_EN
  localparam state_t S_AFTER_DATA = S_STOP;
`else
  localparam state_t S_AFTER_DATA = S_PUSH;
`endif

  state_t                 r_state;
  logic [DATA_BITS-1:0]   r_shift;
  logic [3:0]             r_bit_cnt;
  logic [TW-1:0]          r_to_cnt;
  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [4:0]             r_level;
  logic [DATA_BITS-1:0]   r_last;
  logic                   r_overrun;
  logic                   r_frame_err;

  state_t                 w_state_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic [3:0]             w_bit_cnt_nxt;
  logic [TW-1:0]          w_to_nxt;
  logic                   w_push;
  logic                   w_frame_evt;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_wr;
  logic                   w_ovf_evt;
  logic [DATA_BITS-1:0]   w_head;

  assign w_pop     = rx_valid && rx_ready;
  assign w_full    = (r_level == 5'(FIFO_DEPTH));
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf_evt = w_push && w_full && !w_pop;

  // Next-state logic: bit capture, timeout supervision and stop-bit check.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_to_nxt      = r_to_cnt;
    w_push        = 1'b0;
    w_frame_evt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_to_nxt = '0;
        if (sample_sig) begin
          w_shift_nxt   = DATA_BITS'(din);
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = (DATA_BITS == 1) ? S_AFTER_DATA : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (sample_sig) begin
          w_shift_nxt   = r_shift | (DATA_BITS'(din) << r_bit_cnt);
          w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          w_to_nxt      = '0;
          if (r_bit_cnt == 4'(DATA_BITS - 1)) w_state_nxt = S_AFTER_DATA;
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_frame_evt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
`ifdef RX_STOP_CHECK_EN
      S_STOP: begin
        if (sample_sig) begin
          w_to_nxt = '0;
          if (din) begin
            w_state_nxt = S_PUSH;
          end else begin
            w_frame_evt = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          w_frame_evt = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
`endif
      S_PUSH: begin
        // A strobe arriving here is ignored; the frame is already complete.
        w_push      = 1'b1;
        w_to_nxt    = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM, shift register and counters.
  always_ff @(posedge sample_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_nxt;
    end
  end

  // FIFO storage array. The write pointer always addresses a free or
  // vacating slot.
  always_ff @(posedge sample_clk) begin
    // NOTE: storage has no reset. Entries are only read once level says
    // they were written, so clearing them would add logic without effect.
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  // FIFO pointers, occupancy, and the held copy of the last popped word.
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky error flags. A new event wins over a same-cycle clear.
  always_ff @(posedge sample_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_evt)      r_overrun <= 1'b1;
      else if (clr_flags) r_overrun <= 1'b0;
      if (w_frame_evt)    r_frame_err <= 1'b1;
      else if (clr_flags) r_frame_err <= 1'b0;
    end
  end

  assign rx_valid  = (r_level != 5'd0);
  assign w_head    = rx_valid ? r_mem[r_rd_ptr] : r_last;
  assign rx_data   = 8'(w_head);
  assign level     = r_level;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb_rx_frame_controller
//   Directed and randomized stimulus for rx_frame_controller with default
//   parameters (DATA_BITS=8, FIFO_DEPTH=4, TIMEOUT=40). The reference model
//   is a word queue plus flag bits, updated once per completed frame.
//   Works with or without RX_STOP_CHECK_EN defined.
module tb_rx_frame_controller;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;

  logic       sample_clk = 1'b0;
  logic       rst_n;
  logic       sample_sig;
  logic       din;
  logic       clr_flags;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [4:0] level;
  logic       busy;
  logic       overrun;
  logic       frame_err;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state.
  logic [7:0] q[$];
  logic [7:0] m_last;
  logic       m_ovr;
  logic       m_ferr;

  always #5 sample_clk = ~sample_clk;

  rx_frame_controller dut (
    .sample_clk (sample_clk),
    .rst_n      (rst_n),
    .sample_sig (sample_sig),
    .din        (din),
    .clr_flags  (clr_flags),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .level      (level),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic tick();
    @(posedge sample_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every consumer-visible output against the model.
  task automatic check_state(input string tag);
    logic [7:0] exp_data;
    exp_data = (q.size() != 0) ? q[0] : m_last;
    check({tag, ".level"}, 32'(level), 32'(q.size()));
    check({tag, ".valid"}, 32'(rx_valid), 32'(q.size() != 0));
    check({tag, ".data"}, 32'(rx_data), 32'(exp_data));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic pulse(input logic b);
    sample_sig = 1'b1;
    din        = b;
    tick();
    sample_sig = 1'b0;
    din        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drive one frame; returns while the DUT sits in its push cycle.
  task automatic send_bits(input logic [7:0] w, input int max_gap, input logic stop_bit);
    for (int i = 0; i < 8; i++) begin
      pulse(w[i]);
      if (i < 7) idle($urandom_range(max_gap, 0));
    end
`ifdef RX_STOP_CHECK_EN
    idle($urandom_range(max_gap, 0));
    pulse(stop_bit);
`else
    if (stop_bit) idle(0);
`endif
  endtask

  task automatic model_push(input logic [7:0] w);
    if (q.size() < DEPTH) q.push_back(w);
    else m_ovr = 1'b1;
  endtask

  task automatic send_word(input logic [7:0] w, input int max_gap);
    send_bits(w, max_gap, 1'b1);
    tick();
    model_push(w);
  endtask

  task automatic pop(input string tag);
    check_state(tag);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_last = q.pop_front();
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    int         n;
    rst_n = 1'b0; sample_sig = 1'b0; din = 1'b0; clr_flags = 1'b0; rx_ready = 1'b0;
    m_last = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0;
    idle(3);
    rst_n = 1'b1;
    tick();

    // Reset state.
    check_state("reset");
    check("reset.busy", 32'(busy), 32'd0);

    // 8'hA5 sent LSB first; valid two cycles after the last strobe.
    w = 8'hA5;
    send_bits(w, 0, 1'b1);
    check("a5.push_busy", 32'(busy), 32'd1);
    check("a5.push_valid", 32'(rx_valid), 32'd0);
    tick();
    model_push(w);
    check_state("a5");
    check("a5.data", 32'(rx_data), 32'hA5);
    check("a5.busy", 32'(busy), 32'd0);
    pop("a5.pop");
    check_state("a5.hold");

    // Five words into a four-entry FIFO: the fifth is dropped.
    for (int i = 1; i <= 5; i++) send_word(8'(i), 3);
    check_state("fill5");
    check("fill5.overrun", 32'(overrun), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain.order", 32'(rx_data), 32'(i));
      pop("drain");
    end
    check_state("drained");
    clear_flags();
    check_state("clr1");

    // Timeout: a gap of exactly TIMEOUT cycles is still inside the frame.
    pulse(1'b0); pulse(1'b1); pulse(1'b1);
    idle(TIMEOUT - 1);
    check("to.edge_busy", 32'(busy), 32'd1);
    check("to.edge_ferr", 32'(frame_err), 32'd0);
    tick();
    m_ferr = 1'b1;
    check("to.busy", 32'(busy), 32'd0);
    check_state("timeout");

    // 8'h3C with one maximal legal gap after its first bit.
    w = 8'h3C;
    pulse(w[0]);
    idle(TIMEOUT - 1);
    for (int i = 1; i < 8; i++) pulse(w[i]);
`ifdef RX_STOP_CHECK_EN
    pulse(1'b1);
`endif
    tick();
    model_push(w);
    check_state("3c");
    check("3c.data", 32'(rx_data), 32'h3C);
    pop("3c.pop");

    // Clear and a new timeout in the same cycle: the set wins.
    clear_flags();
    check_state("clr2");
    pulse(1'b1); pulse(1'b1); pulse(1'b0);
    idle(TIMEOUT - 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ferr = 1'b1;
    check_state("set_wins");
    clear_flags();

    // FIFO full with a pop in the push cycle: written, no overrun.
    for (int i = 0; i < DEPTH; i++) send_word(8'($urandom), 2);
    check_state("full");
    w = 8'($urandom);
    send_bits(w, 2, 1'b1);
    check_state("pushpop.pre");
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    m_last = q.pop_front();
    q.push_back(w);
    check_state("pushpop");
    check("pushpop.level", 32'(level), 32'd4);
    for (int i = 0; i < DEPTH; i++) pop("pushpop.drain");
    check_state("pushpop.empty");

`ifdef RX_STOP_CHECK_EN
    // Bad stop bit drops the word; a good one delivers it.
    send_bits(8'h55, 1, 1'b0);
    tick();
    m_ferr = 1'b1;
    check_state("stop.bad");
    check("stop.bad_busy", 32'(busy), 32'd0);
    clear_flags();
    send_word(8'h55, 1);
    check_state("stop.good");
    check("stop.good_data", 32'(rx_data), 32'h55);
    pop("stop.pop");
`endif

    // Randomized frames with random consumer pops.
    for (int k = 0; k < 24; k++) begin
      send_word(8'($urandom), 4);
      check_state("rand.rx");
      n = $urandom_range(2, 0);
      for (int j = 0; j < n; j++) begin
        if (q.size() != 0) pop("rand.pop");
      end
      check_state("rand.after");
    end

    // Reset in mid-frame with words buffered.
    send_word(8'h11, 1);
    pulse(1'b1); pulse(1'b0); pulse(1'b1); pulse(1'b1);
    rst_n = 1'b0;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.level", 32'(level), 32'd0);
    check("rst.valid", 32'(rx_valid), 32'd0);
    check("rst.data", 32'(rx_data), 32'd0);
    tick();
    rst_n = 1'b1;
    q.delete();
    m_last = 8'h00; m_ovr = 1'b0; m_ferr = 1'b0;
    tick();
    check_state("rst.after");

    // Raise both flags, then clear them with one pulse.
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 1);
    pulse(1'b1); pulse(1'b1);
    idle(TIMEOUT);
    m_ferr = 1'b1;
    check_state("flags.set");
    clear_flags();
    check("clr.overrun", 32'(overrun), 32'd0);
    check("clr.frame_err", 32'(frame_err), 32'd0);
    check_state("flags.clr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
